alu4_arbiter: RTL and testbench

- Shares one 4-function ALU (`alu4`, N-bit) between two requesters.
- Each requester presents op/operands with a valid/ready handshake. A round-robin arbiter grants one request per cycle and the ALU computes combinationally.
- The result, flags and requester id are captured in a one-entry output register with its own valid/ready handshake.
- Sits between two issue sources (e.g. two sequencers) and one downstream consumer.

---
 rtl/alu4_arbiter.sv | 97 +++++++++
 tb/tb_alu4_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu4_arbiter.sv
// Two-requester round-robin front end sharing one 4-function ALU, with a single-entry
// response register carrying result, flags and the issuing requester id.
module alu4_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_f,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_f,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_y,
  output logic         rsp_zero,
  output logic         rsp_overflow
);

  logic         rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_overflow_q;
  logic [N-1:0] rsp_y_q;
  logic         ptr_q;

  logic         accept;
  logic         grant;
  logic         xfer;
  logic [2:0]   sel_f;
  logic [N-1:0] sel_a, sel_b, bsel, alu_y;
  logic [N:0]   sum;

  assign accept = !rsp_valid_q || rsp_ready;

  // With both valid the pointer decides; otherwise whichever one is asking.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ptr_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = !reset && accept && req0_valid && !grant;
  assign req1_ready = !reset && accept && req1_valid && grant;
  assign xfer       = req0_ready || req1_ready;

  assign sel_f = grant ? req1_f : req0_f;
  assign sel_a = grant ? req1_a : req0_a;
  assign sel_b = grant ? req1_b : req0_b;

  assign bsel = sel_f[2] ? ~sel_b : sel_b;
  assign sum  = {1'b0, sel_a} + {1'b0, bsel} + {{N{1'b0}}, sel_f[2]};

  always_comb begin
    alu_y = '0;
    unique case (sel_f[1:0])
      2'b00:   alu_y = sel_a & bsel;
      2'b01:   alu_y = sel_a | bsel;
      2'b10:   alu_y = sum[N-1:0];
      default: alu_y = {{(N-1){1'b0}}, sum[N-1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_y_q        <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      ptr_q          <= 1'b0;
    end else if (xfer) begin
      rsp_valid_q    <= 1'b1;
      rsp_id_q       <= grant;
      rsp_y_q        <= alu_y;
      rsp_zero_q     <= (alu_y == '0);
      rsp_overflow_q <= sum[N];
      ptr_q          <= ~grant;
    end else if (rsp_ready) begin
      // Drain only: data outputs keep their last values.
      rsp_valid_q    <= 1'b0;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed plus randomized bench for alu4_arbiter against a transaction-level model.
module tb_alu4_arbiter;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_f, req1_f;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow;
  logic [N-1:0] rsp_y;

  alu4_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_f(req0_f),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_f(req1_f),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state: response register contents and who was served last.
  logic        m_valid, m_id, m_zero, m_ov, m_last;
  logic [31:0] m_y;
  logic        t0, t1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference ALU in plain arithmetic: bit 2 selects subtract (carry = no borrow).
  task automatic alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output logic ov);
    longint unsigned wa, wb, s;
    wa = 64'(a);
    wb = 64'(b);
    if (f[2]) begin
      s  = (wa - wb) & 64'hFFFF_FFFF;
      ov = (wa >= wb);
    end else begin
      s  = wa + wb;
      ov = (s >= 64'h1_0000_0000);
    end
    case (f[1:0])
      2'b00:   y = a & (f[2] ? ~b : b);
      2'b01:   y = a | (f[2] ? ~b : b);
      2'b10:   y = s[31:0];
      default: y = {31'b0, s[31]};
    endcase
  endtask

  task automatic cycle(input string tag);
    logic        e0, e1, g, ov;
    logic [31:0] y;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && (!m_valid || rsp_ready)) begin
      if (req0_valid && req1_valid) begin
        g = !m_last;
      end else begin
        g = req1_valid;
      end
      e0 = req0_valid && !g;
      e1 = req1_valid && g;
    end
    chk({tag, "_rdy0"}, 64'(req0_ready), 64'(e0));
    chk({tag, "_rdy1"}, 64'(req1_ready), 64'(e1));
    t0 = e0;
    t1 = e1;
    if (reset) begin
      m_valid = 0; m_id = 0; m_y = 0; m_zero = 0; m_ov = 0; m_last = 1;
    end else if (e0 || e1) begin
      if (e1) alu_ref(req1_f, req1_a, req1_b, y, ov);
      else    alu_ref(req0_f, req0_a, req0_b, y, ov);
      m_valid = 1; m_id = e1; m_y = y; m_zero = (y == 0); m_ov = ov; m_last = e1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(m_valid));
    chk({tag, "_id"}, 64'(rsp_id), 64'(m_id));
    chk({tag, "_y"}, 64'(rsp_y), 64'(m_y));
    chk({tag, "_zero"}, 64'(rsp_zero), 64'(m_zero));
    chk({tag, "_ovf"}, 64'(rsp_overflow), 64'(m_ov));
  endtask

  task automatic set0(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b);
    req0_valid = v; req0_f = f; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b);
    req1_valid = v; req1_f = f; req1_a = a; req1_b = b;
  endtask

  initial begin
    logic [31:0] held_y;
    m_valid = 0; m_id = 0; m_y = 0; m_zero = 0; m_ov = 0; m_last = 1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b0, 3'd0, 0, 0);
    set1(1'b0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    cycle("reset");
    reset = 1'b0;

    set0(1'b1, 3'b010, 5, 7);
    cycle("add");
    chk("add_y_const", 64'(rsp_y), 64'd12);
    chk("add_id_const", 64'(rsp_id), 64'd0);

    set0(1'b0, 3'b000, 0, 0);
    set1(1'b1, 3'b110, 3, 3);
    cycle("sub_eq");
    chk("sub_eq_zero_const", 64'(rsp_zero), 64'd1);
    chk("sub_eq_ovf_const", 64'(rsp_overflow), 64'd1);
    set1(1'b1, 3'b111, 2, 3);
    cycle("slt");
    chk("slt_y_const", 64'(rsp_y), 64'd1);
    chk("slt_ovf_const", 64'(rsp_overflow), 64'd0);

    // Both valid: strict alternation starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      set1(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      cycle("alt");
      chk("alt_seq", 64'(rsp_id), 64'(i % 2));
    end

    // Backpressure with both valid: outputs frozen, no grants.
    rsp_ready = 1'b0;
    held_y = rsp_y;
    for (int i = 0; i < 3; i++) begin
      cycle("bp");
      chk("bp_hold_y", 64'(rsp_y), 64'(held_y));
    end
    rsp_ready = 1'b1;
    cycle("bp_rel");
    chk("bp_rel_id", 64'(rsp_id), 64'd0);

    set1(1'b0, 3'd0, 0, 0);
    set0(1'b1, 3'b010, 32'hFFFF_FFFF, 1);
    cycle("add_wrap");
    chk("add_wrap_zero_const", 64'(rsp_zero), 64'd1);
    set0(1'b1, 3'b000, 32'hF0, 32'h3C);
    cycle("and");
    chk("and_y_const", 64'(rsp_y), 64'h30);
    set0(1'b1, 3'b101, 0, 32'hFFFF_FFFE);
    cycle("orn");
    chk("orn_y_const", 64'(rsp_y), 64'd1);

    // Reset while a response is pending and a request waits.
    rsp_ready = 1'b0;
    reset = 1'b1;
    cycle("mid_reset");
    chk("mid_reset_valid_const", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    set1(1'b1, 3'b010, 1, 1);
    cycle("post_reset");
    chk("post_reset_id_const", 64'(rsp_id), 64'd0);

    // Random traffic; operands held while a request waits.
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !t0)) begin
        set0($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      if (!(req1_valid && !t1)) begin
        set1($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      rsp_ready = $urandom_range(0, 9) < 7;
      reset = $urandom_range(0, 59) == 0;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
